// File: rtl/mux_pkg.sv
// Shared definitions for the mux scan sequencer and the four_to_two_mux it drives.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int unsigned DATA_W = 4;

endpackage

// File: rtl/dwell_counter.sv
// Counts cycles spent on one select value; `last` marks the final dwell cycle.
module dwell_counter #(
    parameter int unsigned DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last = (count_q == LAST_VAL);

    // Next count: clear wins, otherwise step and restart after the last dwell cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Loads four operands over a valid/ready stream, then steps SE through all
// four select codes, dwelling DWELL cycles on each and strobing `sample`.
module mux_scan_sequencer
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DWELL = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [1:0]       SE,
    output logic             busy,
    output logic             sample,
    output logic             done
);

    state_t           state_q, state_d;
    logic [1:0]       widx_q, widx_d;
    logic [1:0]       se_q, se_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [3:0]       slot_we;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             last;

    assign in_ready   = (state_q == ST_LOAD);
    assign accept     = in_valid && in_ready;
    assign slot_we    = accept ? (4'b0001 << widx_q) : 4'b0000;
    assign cnt_enable = (state_q == ST_SCAN);
    assign sample     = (state_q == ST_SCAN) && last;

    assign A    = a_q;
    assign B    = b_q;
    assign C    = c_q;
    assign D    = d_q;
    assign SE   = se_q;
    assign busy = busy_q;
    assign done = done_q;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (last)
    );

    // Next-state, slot writes and select stepping.
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        se_d      = se_q;
        cnt_clear = 1'b0;
        a_d       = slot_we[0] ? in_data : a_q;
        b_d       = slot_we[1] ? in_data : b_q;
        c_d       = slot_we[2] ? in_data : c_q;
        d_d       = slot_we[3] ? in_data : d_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // 2-bit index wraps to slot A after the fourth word.
                    widx_d = widx_q + 2'd1;
                    if (widx_q == 2'd3) begin
                        se_d      = SEL_A;
                        cnt_clear = 1'b1;
                        state_d   = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (last) begin
                    if (se_q == SEL_D) begin
                        state_d = ST_DONE;
                    end else begin
                        se_d = se_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
                se_d    = SEL_A;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            widx_q  <= '0;
            se_q    <= SEL_A;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            se_q    <= se_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
